unified_divider: RTL
====================

UNIFIED_DIVIDER -- requirements
Module: unified_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  16  dividend; two's complement when sel1=1.
REQ-006 divisor  input  7  divisor; two's complement when sel2=1.
REQ-007 sel1  input  1  dividend signed (1) / unsigned (0).
REQ-008 sel2  input  1  divisor signed (1) / unsigned (0).
REQ-009 busy  output  1  high from the start-accept edge until done is asserted.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 quotient  output  16  result; signed when sel1|sel2, else unsigned.
REQ-012 remainder  output  8  two's complement remainder carrying the dividend's sign.
REQ-013 div_by_zero  output  1  divisor was zero; valid with done, held afterwards.
REQ-014 overflow  output  1  exact quotient not representable in 16 bits; valid with done, held afterwards.

Function
REQ-015 States SHALL be IDLE, PREP, DIV, FIX.
- IDLE->PREP on start=1.
- PREP->DIV after 1 cycle.
- DIV->FIX after exactly 16 cycles.
- FIX->IDLE after 1 cycle.
REQ-016 On the start-accept edge, dividend, divisor, sel1 and sel2 SHALL be registered; later input changes SHALL have no effect on the operation in progress.
REQ-017 PREP SHALL form the operand magnitudes: 16-bit |dividend| and 7-bit |divisor|, where -64 gives 64.
- Result sign = dividend sign XOR divisor sign.
- Sign bits are 0 for an operand whose select is 0.
REQ-018 DIV SHALL perform radix-2 restoring division, one quotient bit per cycle, MSB first, on the magnitudes.
REQ-019 FIX SHALL apply signs and register quotient, remainder, div_by_zero and overflow.
- Quotient is negated if the result sign is 1.
- Remainder is negated if the dividend sign is 1.
REQ-020 done SHALL be high for exactly the one cycle following the FIX edge, i.e. 18 clock edges after the start-accept edge, with outputs valid in that cycle.
- Latency is fixed and independent of operand values.
REQ-021 Outputs SHALL hold their values until the next FIX edge.
REQ-022 start asserted while busy=1 or in the done cycle SHALL be ignored.
- A start in the cycle after done SHALL be accepted.
REQ-023 Divisor zero SHALL give quotient=16'hFFFF, remainder=8'h00, div_by_zero=1, overflow=0, at the same latency.
REQ-024 Overflow rules SHALL be:
- Signed result, positive: overflow when magnitude > 32767.
- Signed result, negative: overflow when magnitude > 32768.
- Unsigned result: never overflows.
- On overflow, quotient = low 16 bits of the exact two's complement result.
REQ-025 The quotient magnitude path SHALL be at least 17 bits wide so that magnitude 65535 and its negation are computed exactly before truncation.

Reset
REQ-026 While rst_n=0, the block SHALL go to IDLE immediately, independent of clk.
- busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- All internal registers cleared.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
- After release, the first start SHALL complete normally at the REQ-020 latency.

Verification
REQ-028 sel1=0, sel2=0, dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0, done exactly 18 edges after start.
REQ-029 sel1=1, sel2=1, dividend=16'hFF9C (-100), divisor=7'h07 -> quotient=16'hFFF2 (-14), remainder=8'hFE (-2).
REQ-030 sel1=1, sel2=1, dividend=50, divisor=7'h76 (-10) -> quotient=16'hFFFB, remainder=0; then dividend=1234, divisor=0 -> quotient=16'hFFFF, remainder=0, div_by_zero=1.
REQ-031 Overflow cases:
- sel1=1, sel2=1, dividend=16'h8000, divisor=7'h7F -> quotient=16'h8000, overflow=1.
- sel1=0, sel2=1, dividend=16'hFFFF, divisor=7'h7F -> quotient=16'h0001, overflow=1.
REQ-032 Start pulsed again 5 cycles into an operation -> ignored; one done only, with the first operation's results.
REQ-033 rst_n low for 1 cycle at cycle 8 of an operation -> outputs 0, no done; next start with 1000/7 -> 142 r 6 after 18 edges.

Source files
------------

// File: rtl/unified_divider.sv
// unified_divider: 16-bit by 7-bit sequential divider with independent operand
// signedness, radix-2 restoring core and fixed 18-edge start-to-done latency.
module unified_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [6:0]  divisor,
  input  logic        sel1,
  input  logic        sel2,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int unsigned DVD_W  = 16;
  localparam int unsigned DVS_W  = 7;
  localparam int unsigned REM_W  = 8;
  localparam int unsigned QEXT_W = DVD_W + 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  state_e             state_q;

  // captured request
  logic [DVD_W-1:0]   dvd_q;
  logic [DVS_W-1:0]   dvs_q;
  logic               sel1_q;
  logic               sel2_q;

  // datapath
  logic [DVD_W-1:0]   acc_q;      // dividend magnitude, shifts into quotient
  logic [DVS_W-1:0]   part_q;     // partial remainder (always < divisor)
  logic [DVS_W-1:0]   dvs_mag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dvd_neg_q;
  logic               res_neg_q;
  logic               signed_q;

  // registered outputs
  logic               busy_q;
  logic               done_q;
  logic [DVD_W-1:0]   quo_q;
  logic [REM_W-1:0]   rem_q;
  logic               dbz_q;
  logic               ovf_q;

  // combinational next values
  logic               dvd_neg_d;
  logic               dvs_neg_d;
  logic [DVD_W-1:0]   dvd_mag_d;
  logic [DVS_W-1:0]   dvs_mag_d;
  logic [DVS_W:0]     part_sh;
  logic               q_bit;
  logic [DVS_W-1:0]   part_d;
  logic [DVD_W-1:0]   acc_d;
  logic [QEXT_W-1:0]  q_ext;
  logic [QEXT_W-1:0]  q_res;
  logic               ovf_d;
  logic [REM_W-1:0]   rem_ext;
  logic [REM_W-1:0]   rem_d;
  logic               dbz_d;

  // Operand magnitudes and signs from the captured request.
  always_comb begin
    dvd_neg_d = sel1_q & dvd_q[DVD_W-1];
    dvs_neg_d = sel2_q & dvs_q[DVS_W-1];
    dvd_mag_d = dvd_neg_d ? DVD_W'(~dvd_q + DVD_W'(1)) : dvd_q;
    dvs_mag_d = dvs_neg_d ? DVS_W'(~dvs_q + DVS_W'(1)) : dvs_q;
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    part_sh = {part_q, acc_q[DVD_W-1]};
    q_bit   = (part_sh >= {1'b0, dvs_mag_q});
    part_d  = q_bit ? DVS_W'(part_sh - {1'b0, dvs_mag_q}) : part_sh[DVS_W-1:0];
    acc_d   = {acc_q[DVD_W-2:0], q_bit};
  end

  // Sign fix-up; the 17-bit result keeps -65535 exact so overflow is just
  // "top two bits disagree" for a signed result.
  always_comb begin
    q_ext   = {1'b0, acc_q};
    q_res   = res_neg_q ? QEXT_W'(~q_ext + QEXT_W'(1)) : q_ext;
    ovf_d   = signed_q & (q_res[QEXT_W-1] ^ q_res[QEXT_W-2]);
    rem_ext = {1'b0, part_q};
    rem_d   = dvd_neg_q ? REM_W'(~rem_ext + REM_W'(1)) : rem_ext;
    dbz_d   = (dvs_mag_q == '0);
  end

  // Control FSM and all state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sel1_q    <= 1'b0;
      sel2_q    <= 1'b0;
      acc_q     <= '0;
      part_q    <= '0;
      dvs_mag_q <= '0;
      cnt_q     <= '0;
      dvd_neg_q <= 1'b0;
      res_neg_q <= 1'b0;
      signed_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // a start coinciding with the done pulse is dropped
          if (start && !done_q) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            sel1_q  <= sel1;
            sel2_q  <= sel2;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          acc_q     <= dvd_mag_d;
          dvs_mag_q <= dvs_mag_d;
          part_q    <= '0;
          cnt_q     <= '0;
          dvd_neg_q <= dvd_neg_d;
          res_neg_q <= dvd_neg_d ^ dvs_neg_d;
          signed_q  <= sel1_q | sel2_q;
          state_q   <= DIV;
        end
        DIV: begin
          acc_q  <= acc_d;
          part_q <= part_d;
          cnt_q  <= CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dbz_d) begin
            quo_q <= '1;
            rem_q <= '0;
            dbz_q <= 1'b1;
            ovf_q <= 1'b0;
          end else begin
            quo_q <= q_res[DVD_W-1:0];
            rem_q <= rem_d;
            dbz_q <= 1'b0;
            ovf_q <= ovf_d;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
